// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a synchronous FIFO: issues credit-limited reads and
// re-presents the registered FIFO output as a full-throughput valid/ready stream.
module fifo_stream_reader #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [DSIZE-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int unsigned OCC_W    = 2;
    localparam int unsigned CREDIT_W = 3;
    localparam int unsigned DEPTH    = 2;

    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    occ_p;
    logic [OCC_W-1:0]    occ_n;
    logic                infl;
    logic [DSIZE-1:0]    head;
    logic [DSIZE-1:0]    tail;
    logic [DSIZE-1:0]    head_n;
    logic [DSIZE-1:0]    tail_n;
    logic                pop;
    logic [CREDIT_W-1:0] credit;

    // Read credit counts this cycle's pop so a steady stream never stalls.
    always_comb begin
        pop        = m_valid & m_ready;
        credit     = CREDIT_W'(occ) + CREDIT_W'(infl) - CREDIT_W'(pop);
        fifo_rd_en = !rstn && !fifo_empty && (credit < CREDIT_W'(DEPTH));
    end

    // Pop first, then place the returning word behind whatever remains.
    always_comb begin
        occ_p  = occ - OCC_W'(pop);
        head_n = (pop && (occ == OCC_W'(2))) ? tail : head;
        tail_n = tail;
        occ_n  = occ_p;
        if (infl) begin
            if (occ_p == '0) begin
                head_n = fifo_dout;
            end else begin
                tail_n = fifo_dout;
            end
            occ_n = occ_p + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            occ        <= '0;
            infl       <= 1'b0;
            head       <= '0;
            tail       <= '0;
            m_valid    <= 1'b0;
            xfer_count <= '0;
        end else begin
            occ     <= occ_n;
            infl    <= fifo_rd_en;
            head    <= head_n;
            tail    <= tail_n;
            m_valid <= (occ_n != '0);
            if (pop) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

    assign m_data = head;

    // A capture arriving into a full buffer means the credit rule was broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (rstn)
        !(infl && (occ_p == OCC_W'(DEPTH))))
        else $error("fifo_stream_reader: capture into full buffer");

    a_occ_range : assert property (@(posedge clk) disable iff (rstn)
        occ <= OCC_W'(DEPTH))
        else $error("fifo_stream_reader: occupancy out of range");

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural synchronous FIFO;
// a negedge monitor checks stream order and hold-stability independently of stimulus.
module tb_fifo_stream_reader;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DSIZE-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic [CNT_W-1:0] xfer_count;

    logic [DSIZE-1:0] fq[$];
    logic [DSIZE-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    logic             prev_v;
    logic             prev_pop;
    logic [DSIZE-1:0] prev_d;
    logic [DSIZE-1:0] exp_w;

    fifo_stream_reader #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered dout, empty flag updated on the clock edge.
    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_dout  <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) fifo_dout <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted word must be the next expected one; held data must not change.
    always @(negedge clk) begin
        if (!rstn) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("stream_data", 32'(m_data), 32'(exp_w));
                end
            end
            if (prev_v && !prev_pop && m_valid) chk("hold_stable", 32'(m_data), 32'(prev_d));
            prev_v   = m_valid;
            prev_pop = m_valid && m_ready;
            prev_d   = m_data;
        end else begin
            prev_v   = 1'b0;
            prev_pop = 1'b0;
        end
    end

    task automatic push(input logic [DSIZE-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || m_valid) begin
            failures++;
            $display("FAIL %s_drain: got %0d words left expected 0", nm, exp_q.size());
        end
    endtask

    initial begin
        int rd_i;
        int v_i;
        int n;
        rstn    = 1'b1;
        m_ready = 1'b1;
        prev_v  = 1'b0;
        prev_pop = 1'b0;
        prev_d  = '0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;

        // Three words with ready high: first valid two cycles after first read.
        @(posedge clk); #1;
        push(8'h11); push(8'h22); push(8'h33);
        rd_i = -1; v_i = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_rd_en && rd_i < 0) rd_i = i;
            if (m_valid && v_i < 0) v_i = i;
        end
        chk("first_valid_latency", 32'(v_i - rd_i), 32'd2);
        drain("three");
        chk("xfer_three", 32'(xfer_count), 32'd3);

        // Sixteen prefilled words stream with no bubbles.
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_valid) n++;
            @(negedge clk);
        end
        chk("no_bubbles", 32'(n), 32'd16);
        drain("sixteen");
        chk("xfer_sixteen_wrapped", 32'(xfer_count), 32'd0);

        // Backpressure: only two reads while ready is low, head held.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) n++;
        end
        chk("bp_rd_pulses", 32'(n), 32'd2);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_head", 32'(m_data), 32'h51);
        @(posedge clk); #1;
        m_ready = 1'b1;
        drain("backpressure");
        chk("xfer_five", 32'(xfer_count), 32'd5);

        // Ready toggling every cycle preserves order.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        drain("toggle");
        chk("xfer_eight", 32'(xfer_count), 32'd8);

        // Counter wrap at 4 bits.
        do_reset();
        for (int i = 0; i < 15; i++) push(8'h60 + 8'(i));
        drain("wrap15");
        chk("xfer_f", 32'(xfer_count), 32'hF);
        @(posedge clk); #1;
        push(8'h7E);
        drain("wrap16");
        chk("xfer_wrap_0", 32'(xfer_count), 32'h0);
        @(posedge clk); #1;
        push(8'h7F);
        drain("wrap17");
        chk("xfer_wrap_1", 32'(xfer_count), 32'h1);

        // Asynchronous reset mid-stream with words buffered and a read in flight.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        repeat (5) @(negedge clk);
        #2;
        rstn = 1'b1;
        #1;
        exp_q.delete();
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_m_data", 32'(m_data), 32'd0);
        chk("async_xfer", 32'(xfer_count), 32'd0);
        chk("async_rd_en", 32'(fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) n++;
        end
        chk("no_stale_valid", 32'(n), 32'd0);
        @(posedge clk); #1;
        push(8'hE7);
        drain("post_reset");
        chk("xfer_post_reset", 32'(xfer_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
